// File: rtl/clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_prog
// Brief    : Runtime-programmable clock divider with tick strobe, enable,
//            synchronous phase restart and square/pulse output modes.
// Revision : 1.0
// ============================================================================
module clock_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             mode,
   input  logic [WIDTH-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_cur
);

   localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] c_min_div     = WIDTH'(2);
   localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

   logic [WIDTH-1:0] r_div_q;
   logic [WIDTH-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_tick;

   logic [WIDTH-1:0] w_div_eff;
   logic [WIDTH-1:0] w_half;
   logic [WIDTH-1:0] w_cnt_inc;
   logic             w_wrap;

   // Divide-by-1 is unsupported; anything below 2 is coerced to 2.
   assign w_div_eff = (div_in < c_min_div) ? c_min_div : div_in;
   assign w_half    = r_div_q >> 1;
   assign w_cnt_inc = r_cnt + c_one;
   assign w_wrap    = (r_cnt == (r_div_q - c_one));

   // Reset leaves cnt at the last count so the first enabled edge starts a period.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_div_q   <= c_default_div;
         r_cnt     <= c_default_div - c_one;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else if (sync_clr || (en && w_wrap)) begin
         r_cnt     <= '0;
         r_div_q   <= w_div_eff;
         r_tick    <= 1'b1;
         r_clk_out <= 1'b1;
      end else if (en) begin
         r_cnt     <= w_cnt_inc;
         r_tick    <= 1'b0;
         r_clk_out <= mode ? 1'b0 : (w_cnt_inc < w_half);
      end else begin
         r_tick    <= 1'b0;
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;
   assign div_cur = r_div_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_prog
// Brief    : Directed self-checking bench for clock_div_prog.
// Revision : 1.0
// ============================================================================
module tb_clock_div_prog;

   logic       clk_in;
   logic       reset;
   logic       en;
   logic       sync_clr;
   logic       mode;
   logic [7:0] div_in;
   logic       clk_out;
   logic       tick;
   logic [7:0] div_cur;

   int checks   = 0;
   int failures = 0;
   int edge_no  = 0;

   clock_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (en),
      .sync_clr (sync_clr),
      .mode     (mode),
      .div_in   (div_in),
      .clk_out  (clk_out),
      .tick     (tick),
      .div_cur  (div_cur)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic et, input logic ec, input logic [7:0] ed);
      chk($sformatf("%s_e%0d_tick", tag, edge_no), {7'd0, tick}, {7'd0, et});
      chk($sformatf("%s_e%0d_clk_out", tag, edge_no), {7'd0, clk_out}, {7'd0, ec});
      chk($sformatf("%s_e%0d_div_cur", tag, edge_no), div_cur, ed);
   endtask

   // Advance one rising edge, then sample 1 ns later.
   task automatic step(input string tag, input logic et, input logic ec, input logic [7:0] ed);
      @(posedge clk_in);
      #1;
      edge_no++;
      chk_outs(tag, et, ec, ed);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      en       = 1'b0;
      sync_clr = 1'b0;
      mode     = 1'b0;
      div_in   = 8'd4;
      repeat (2) @(posedge clk_in);
      #1;
      chk_outs("reset", 1'b0, 1'b0, 8'd4);
      reset = 1'b0;
      en    = 1'b1;

      // Divide by 4: tick on first edge, clk_out 1,1,0,0
      step("d4", 1, 1, 4);
      step("d4", 0, 1, 4);
      step("d4", 0, 0, 4);
      step("d4", 0, 0, 4);
      step("d4", 1, 1, 4);
      step("d4", 0, 1, 4);

      // Mid-period change to 5: current period still 4 long
      div_in = 8'd5;
      step("d4to5", 0, 0, 4);
      step("d4to5", 0, 0, 4);
      step("d5", 1, 1, 5);
      step("d5", 0, 1, 5);
      for (int i = 0; i < 3; i++) step("d5", 0, 0, 5);
      step("d5", 1, 1, 5);

      // div_in=0 coerces to 2 at the next period start
      div_in = 8'd0;
      step("d5to0", 0, 1, 5);
      for (int i = 0; i < 3; i++) step("d5to0", 0, 0, 5);
      step("d0", 1, 1, 2);
      step("d0", 0, 0, 2);
      div_in = 8'd1;
      step("d1", 1, 1, 2);
      step("d1", 0, 0, 2);

      // D=6 with en dropped for 3 cycles in the high phase
      div_in = 8'd6;
      step("d6", 1, 1, 6);
      step("d6", 0, 1, 6);
      en = 1'b0;
      for (int i = 0; i < 3; i++) step("d6_hold", 0, 1, 6);
      en = 1'b1;
      step("d6", 0, 1, 6);
      for (int i = 0; i < 3; i++) step("d6", 0, 0, 6);
      step("d6_next", 1, 1, 6);
      step("d6_next", 0, 1, 6);
      step("d6_next", 0, 1, 6);
      for (int i = 0; i < 3; i++) step("d6_next", 0, 0, 6);

      // D=8 with sync_clr at cnt=2
      div_in = 8'd8;
      step("d8", 1, 1, 8);
      step("d8", 0, 1, 8);
      step("d8", 0, 1, 8);
      sync_clr = 1'b1;
      step("d8_clr", 1, 1, 8);
      sync_clr = 1'b0;
      for (int i = 0; i < 3; i++) step("d8", 0, 1, 8);
      for (int i = 0; i < 4; i++) step("d8", 0, 0, 8);
      step("d8_tick", 1, 1, 8);

      // Pulse mode, D=3 loaded at next period start
      mode   = 1'b1;
      div_in = 8'd3;
      for (int i = 0; i < 7; i++) step("pulse_d8", 0, 0, 8);
      step("pulse_d3", 1, 1, 3);
      step("pulse_d3", 0, 0, 3);
      step("pulse_d3", 0, 0, 3);
      step("pulse_d3", 1, 1, 3);
      step("pulse_d3", 0, 0, 3);
      step("pulse_d3", 0, 0, 3);
      step("pulse_d3", 1, 1, 3);

      // Asynchronous reset between edges
      #2;
      reset = 1'b1;
      #1;
      chk_outs("async_reset", 1'b0, 1'b0, 8'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed divide-by-4 clock divider (100 MHz to 25 MHz).
- Divides clk_in by a divisor D selected at run time. Produces a registered divided clock, clk_out, and a one-cycle tick strobe at each period start.
- Adds enable, synchronous phase restart, and square/pulse output modes.
- Sits between the board oscillator and the slower display, audio and game-logic domains. Downstream logic should use tick as a clock enable in preference to clk_out.

Parameters:
- WIDTH, 8: width of the divisor and the internal counter.
- DEFAULT_DIV, 4: divisor in effect from reset until the first reload. Must be in 2..2^WIDTH-1.

Ports:
- clk_in, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: count enable. When 0, all state freezes.
- sync_clr, input, 1: synchronous phase restart. Forces an immediate period start.
- mode, input, 1: 0 selects square output; 1 selects pulse output (clk_out equals tick).
- div_in, input, WIDTH: requested divisor. Sampled only at period boundaries.
- clk_out, output, 1: registered divided clock.
- tick, output, 1: one-cycle strobe marking the first cycle of each period.
- div_cur, output, WIDTH: divisor currently in effect.

Behaviour:
- Reset (asynchronous, active-high) sets the following:
  - div_q = DEFAULT_DIV
  - cnt = DEFAULT_DIV-1
  - clk_out = 0
  - tick = 0
  - div_cur = DEFAULT_DIV
- Coercion: div_eff = (div_in < 2) ? 2 : div_in. Divide-by-1 is not supported.
- half = div_q >> 1 (floor). In square mode the high phase lasts half cycles and the low phase lasts div_q - half cycles. Odd divisors are low-biased, e.g. D=5 gives 2 high, 3 low.
- Per rising edge, evaluated in priority order reset > sync_clr > en:
  - **sync_clr=1 (regardless of en): period start.**
    - cnt <= 0
    - div_q <= div_eff
    - tick <= 1
    - clk_out <= 1
  - **en=0 and sync_clr=0:** cnt, div_q and clk_out hold. tick <= 0.
  - **en=1 and cnt == div_q-1 (wrap): period start**, identical to the sync_clr case.
  - **en=1, otherwise:**
    - cnt <= cnt+1
    - tick <= 0
    - clk_out <= mode ? 0 : ((cnt+1) < half_q), where half_q is the half of the current div_q.
- First period after reset: because cnt resets to DEFAULT_DIV-1, the first enabled edge after reset release is a period start. At that edge tick=1, clk_out=1, and div_in is loaded.
- Divisor change: a new div_in takes effect only at the next period start. There are no truncated or runt periods from a div_in change alone.
- Period boundary: every period is exactly div_q enabled cycles. tick is high for one clk_in cycle per period.
- mode change: takes effect from the next edge's clk_out computation. In pulse mode, clk_out equals tick exactly.
- en low mid-period: the period is stretched by the number of disabled cycles. The phase resumes exactly where it stopped.
- sync_clr mid-period: the current period is truncated, and a new period starts on that edge.
- sync_clr held high: tick stays high and clk_out stays 1 (degenerate, documented).
- Reset asserted mid-period: outputs go to reset values immediately, without waiting for a clock edge.
- div_cur always equals div_q.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset, then release with en=1, div_in=4, mode=0.
   - Required: tick on the 1st edge, then every 4 edges.
   - clk_out follows the pattern 1,1,0,0 repeating, giving 25 MHz from a 10 ns clock.
   - div_cur=4.
2. Change div_in to 5 mid-period.
   - Required: the current period completes with 4 cycles.
   - Subsequent periods are 5 cycles, with clk_out high 2 and low 3.
   - div_cur switches to 5 at the tick edge.
3. Set div_in=0, then div_in=1.
   - Required: both coerce to 2. clk_out toggles every edge, tick every 2 edges, div_cur=2.
4. Drop en for 3 cycles mid-high-phase with D=6.
   - Required: clk_out and cnt freeze and tick=0.
   - That period measures 9 edges; the following periods measure 6 edges.
5. Assert sync_clr for 1 cycle at cnt=2 with D=8.
   - Required: tick=1 and clk_out=1 on that edge.
   - The next tick follows 8 edges later.
6. Set mode=1 with D=3, then assert reset asynchronously between edges.
   - Required: clk_out equals tick (a one-cycle pulse every 3 edges).
   - On reset, clk_out, tick=0 and div_cur=4 take effect immediately without a clock edge.
